clk_rst_sequencer: RTL and testbench
====================================

Name: clk_rst_sequencer

Overview:
- Sequences the board PLL: drives its reset, qualifies its lock, and releases the system reset only after lock has been continuously stable.
- Retries PLL reset on lock timeout, declares a fault after too many retries, and re-enters the reset sequence on loss of lock or a soft reset request.
- Runs on the free-running 25 MHz reference clock, not on the PLL output. Sits between the PLL instance and the reset synchronizers of the core clock domain.

Parameters:
PLL_RST_CYCLES, 16, cycles pll_rst is held high per attempt (>=1)
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before an attempt counts as failed (>=2)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before release (>=1)
MAX_RETRIES, 4, failed attempts tolerated before FAULT (>=1)
SYNC_STAGES, 2, flip-flop stages on locked_in (>=2)

Ports:
clk  in  1  reference clock, 25 MHz, free-running
rst  in  1  asynchronous, active-high reset
locked_in  in  1  PLL lock, asynchronous to clk
soft_rst_req  in  1  synchronous to clk; 1-cycle pulse requests a full re-sequence
pll_rst  out  1  PLL reset, active-high
sys_rst  out  1  system reset, active-high; consumer re-synchronizes it into the PLL domain
ready  out  1  high in RUN only
fault  out  1  sticky; high in FAULT
lock_lost  out  1  1-cycle pulse on lock loss in RUN
retry_count  out  $clog2(MAX_RETRIES+1)  failed attempts since last RUN entry
state_dbg  out  3  encoded state: 0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAULT

Behaviour:
- All outputs are registered.
- Reset values (async, while rst=1): state PLL_RST, cnt 0, pll_rst=1, sys_rst=1, ready=0, fault=0, lock_lost=0, retry_count=0, sync chain all 0.
- locked_s is locked_in after SYNC_STAGES flops. All lock decisions use locked_s only.
- One shared counter, cnt, is cleared on every state entry.
- PLL_RST: pll_rst=1, sys_rst=1. When cnt==PLL_RST_CYCLES-1, go to WAIT_LOCK. pll_rst is therefore high for exactly PLL_RST_CYCLES cycles after rst deassertion.
- WAIT_LOCK: pll_rst=0, sys_rst=1.
  - If locked_s=1, go to STABLE.
  - Otherwise, if cnt==LOCK_TIMEOUT-1, increment retry_count. If the new value equals MAX_RETRIES, go to FAULT; else go to PLL_RST.
  - If both conditions hold in the same cycle, lock wins.
- STABLE: pll_rst=0, sys_rst=1.
  - If locked_s=0, return to WAIT_LOCK. The timeout restarts from 0; retry_count is unchanged.
  - If cnt==LOCK_STABLE_CYCLES-1 with locked_s=1, go to RUN.
- RUN entry: sys_rst=0, ready=1, retry_count cleared to 0 on the same edge.
- RUN exit on lock loss: if locked_s=0, then on the next edge sys_rst=1, ready=0, lock_lost=1 for one cycle, and state goes to PLL_RST.
- RUN exit on soft reset: if soft_rst_req=1 and locked_s=1, same as lock loss except lock_lost stays 0.
  - If both occur in the same cycle, lock_lost=1.
  - soft_rst_req is ignored in every state other than RUN.
- FAULT: pll_rst=1, sys_rst=1, ready=0, fault=1. Terminal; only rst exits.
- Release latency from the first locked_in=1 sample, with lock steady: SYNC_STAGES cycles to locked_s, 1 cycle to enter STABLE, LOCK_STABLE_CYCLES cycles to RUN.
- Invariants:
  - sys_rst=0 only in RUN.
  - pll_rst=1 only in PLL_RST and FAULT.
  - ready equals (state==RUN).
- rst asserted in any state, including mid-count, returns all outputs to reset values immediately, without waiting for a clock edge.

Test Plan:
Use PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=3, SYNC_STAGES=2.
1. Nominal: release rst; raise locked_in 10 cycles later -> pll_rst high exactly 4 cycles; sys_rst falls and ready rises 2+1+8=11 cycles after the locked_in rise; retry_count=0.
2. Glitchy lock: in STABLE, drop locked_in for 1 cycle at stable cnt=5 -> state returns to WAIT_LOCK, then STABLE again; sys_rst still 1; RUN is reached 8 cycles after the second STABLE entry.
3. Timeout retry: locked_in held 0 -> pll_rst pulses of 4 cycles each, 32 cycles apart; retry_count steps 1, 2; on the third timeout state goes to FAULT, fault=1, pll_rst=1; locked_in=1 afterwards has no effect; rst clears everything.
4. Lock loss in RUN: drop locked_in -> 2 sync cycles later lock_lost is a 1-cycle pulse and sys_rst=1 on the same edge; full sequence replays; retry_count was 0 at entry to RUN.
5. Soft reset: pulse soft_rst_req in RUN -> sys_rst=1 next cycle, lock_lost=0, pll_rst=1 for 4 cycles; the same pulse in WAIT_LOCK is ignored.
6. Async reset mid-STABLE: assert rst between clock edges -> pll_rst=1, sys_rst=1, state_dbg=0 before the next edge.

Source files
------------

// File: rtl/clk_rst_sequencer.sv
// clk_rst_sequencer
//   Sequences the board PLL from the free-running reference clock. It pulses
//   the PLL reset, waits for a synchronized lock, and requires the lock to be
//   continuously stable before it releases the system reset. A lock timeout
//   triggers a retry, and too many retries end in a sticky fault. Lock loss or
//   a soft reset request while running replays the whole sequence.
//
// Ports
//   clk          in   reference clock (25 MHz, free-running)
//   rst          in   asynchronous active-high reset
//   locked_in    in   PLL lock, asynchronous to clk
//   soft_rst_req in   1-cycle request for a full re-sequence (honoured in RUN only)
//   pll_rst      out  PLL reset, active-high
//   sys_rst      out  system reset, active-high, low only in RUN
//   ready        out  high in RUN only
//   fault        out  sticky fault flag, high in FAULT
//   lock_lost    out  1-cycle pulse when lock drops while in RUN
//   retry_count  out  failed lock attempts since the last RUN entry
//   state_dbg    out  0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAULT
module clk_rst_sequencer #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES        = 4,
    parameter int SYNC_STAGES        = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             locked_in,
    input  logic                             soft_rst_req,
    output logic                             pll_rst,
    output logic                             sys_rst,
    output logic                             ready,
    output logic                             fault,
    output logic                             lock_lost,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count,
    output logic [2:0]                       state_dbg
);

    localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ? CNT_MAX_A : LOCK_STABLE_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX);
    localparam int RC_W      = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RC_W-1:0]  RETRY_LIMIT  = RC_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [RC_W-1:0]        retry_n;
    logic                   lock_lost_n;
    logic [SYNC_STAGES-1:0] sync_p;
    logic                   locked_s;

    // Lock synchronizer: locked_in enters at bit 0, locked_s leaves the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], locked_in};
        end
    end

    assign locked_s = sync_p[SYNC_STAGES-1];

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_PLL_RST;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
            lock_lost   <= 1'b0;
            retry_count <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            pll_rst     <= (state_n == S_PLL_RST) || (state_n == S_FAULT);
            sys_rst     <= (state_n != S_RUN);
            ready       <= (state_n == S_RUN);
            fault       <= (state_n == S_FAULT);
            lock_lost   <= lock_lost_n;
            retry_count <= retry_n;
        end
    end

    assign state_dbg = state;

    always_comb begin
        state_n     = state;
        retry_n     = retry_count;
        lock_lost_n = 1'b0;
        // Saturating so RUN and FAULT can sit indefinitely without wrapping.
        cnt_n       = (&cnt) ? cnt : cnt + 1'b1;

        case (state)
            S_PLL_RST: begin
                if (cnt == PLL_RST_LAST) begin
                    state_n = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                // Lock takes priority over a timeout landing on the same cycle.
                if (locked_s) begin
                    state_n = S_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    retry_n = retry_count + 1'b1;
                    state_n = (retry_n == RETRY_LIMIT) ? S_FAULT : S_PLL_RST;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_n = S_WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_n = S_RUN;
                    retry_n = '0;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_n     = S_PLL_RST;
                    lock_lost_n = 1'b1;
                end else if (soft_rst_req) begin
                    state_n = S_PLL_RST;
                end
            end
            S_FAULT: begin
                state_n = S_FAULT;
            end
            default: begin
                state_n = S_PLL_RST;
            end
        endcase

        // Every state entry starts the shared counter from zero.
        if (state_n != state) begin
            cnt_n = '0;
        end
    end

endmodule

// File: tb/tb_clk_rst_sequencer.sv
module tb_clk_rst_sequencer;

    localparam int PRC = 4;
    localparam int LTO = 32;
    localparam int LSC = 8;
    localparam int MXR = 3;
    localparam int SYN = 2;
    localparam int RCW = $clog2(MXR + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           locked_in = 1'b0;
    logic           soft_rst_req = 1'b0;
    logic           pll_rst, sys_rst, ready, fault, lock_lost;
    logic [RCW-1:0] retry_count;
    logic [2:0]     state_dbg;

    int total = 0;
    int bad   = 0;

    clk_rst_sequencer #(
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT(LTO),
        .LOCK_STABLE_CYCLES(LSC),
        .MAX_RETRIES(MXR),
        .SYNC_STAGES(SYN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .locked_in(locked_in),
        .soft_rst_req(soft_rst_req),
        .pll_rst(pll_rst),
        .sys_rst(sys_rst),
        .ready(ready),
        .fault(fault),
        .lock_lost(lock_lost),
        .retry_count(retry_count),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Hold rst for two edges and release it 1 time unit after an edge.
    task automatic do_reset(input logic lk);
        rst = 1'b1;
        soft_rst_req = 1'b0;
        locked_in = lk;
        ticks(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ticks(2);
        total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL reset_pll_rst got=%b want=1", pll_rst); end
        total++; if (sys_rst !== 1'b1) begin bad++; $display("FAIL reset_sys_rst got=%b want=1", sys_rst); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b want=0", fault); end
        total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL reset_lock_lost got=%b want=0", lock_lost); end
        total++; if (retry_count !== '0) begin bad++; $display("FAIL reset_retry got=%0d want=0", retry_count); end
        total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_dbg); end
    endtask

    task automatic test_nominal();
        do_reset(1'b0);
        ticks(3);
        total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL nom_pll_rst_t3 got=%b want=1", pll_rst); end
        tick();
        total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL nom_pll_rst_t4 got=%b want=0", pll_rst); end
        total++; if (state_dbg !== 3'd1) begin bad++; $display("FAIL nom_state_t4 got=%0d want=1", state_dbg); end
        ticks(6);
        locked_in = 1'b1;
        ticks(10);
        total++; if (sys_rst !== 1'b1) begin bad++; $display("FAIL nom_sys_rst_l10 got=%b want=1", sys_rst); end
        total++; if (state_dbg !== 3'd2) begin bad++; $display("FAIL nom_state_l10 got=%0d want=2", state_dbg); end
        tick();
        total++; if (sys_rst !== 1'b0) begin bad++; $display("FAIL nom_sys_rst_l11 got=%b want=0", sys_rst); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL nom_ready_l11 got=%b want=1", ready); end
        total++; if (state_dbg !== 3'd3) begin bad++; $display("FAIL nom_state_l11 got=%0d want=3", state_dbg); end
        total++; if (retry_count !== '0) begin bad++; $display("FAIL nom_retry got=%0d want=0", retry_count); end
    endtask

    task automatic test_glitch();
        do_reset(1'b1);
        ticks(5);
        total++; if (state_dbg !== 3'd2) begin bad++; $display("FAIL gl_state_t5 got=%0d want=2", state_dbg); end
        ticks(3);
        locked_in = 1'b0;
        tick();
        locked_in = 1'b1;
        tick();
        total++; if (state_dbg !== 3'd2) begin bad++; $display("FAIL gl_state_t10 got=%0d want=2", state_dbg); end
        tick();
        total++; if (state_dbg !== 3'd1) begin bad++; $display("FAIL gl_state_t11 got=%0d want=1", state_dbg); end
        total++; if (sys_rst !== 1'b1) begin bad++; $display("FAIL gl_sys_rst_t11 got=%b want=1", sys_rst); end
        tick();
        total++; if (state_dbg !== 3'd2) begin bad++; $display("FAIL gl_state_t12 got=%0d want=2", state_dbg); end
        ticks(7);
        total++; if (sys_rst !== 1'b1) begin bad++; $display("FAIL gl_sys_rst_t19 got=%b want=1", sys_rst); end
        tick();
        total++; if (state_dbg !== 3'd3) begin bad++; $display("FAIL gl_state_t20 got=%0d want=3", state_dbg); end
        total++; if (sys_rst !== 1'b0) begin bad++; $display("FAIL gl_sys_rst_t20 got=%b want=0", sys_rst); end
    endtask

    task automatic test_timeout();
        do_reset(1'b0);
        ticks(35);
        total++; if (state_dbg !== 3'd1) begin bad++; $display("FAIL to_state_t35 got=%0d want=1", state_dbg); end
        total++; if (retry_count !== RCW'(0)) begin bad++; $display("FAIL to_retry_t35 got=%0d want=0", retry_count); end
        tick();
        total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL to_state_t36 got=%0d want=0", state_dbg); end
        total++; if (retry_count !== RCW'(1)) begin bad++; $display("FAIL to_retry_t36 got=%0d want=1", retry_count); end
        total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL to_pll_rst_t36 got=%b want=1", pll_rst); end
        ticks(3);
        total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL to_pll_rst_t39 got=%b want=1", pll_rst); end
        tick();
        total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL to_pll_rst_t40 got=%b want=0", pll_rst); end
        ticks(32);
        total++; if (retry_count !== RCW'(2)) begin bad++; $display("FAIL to_retry_t72 got=%0d want=2", retry_count); end
        total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL to_state_t72 got=%0d want=0", state_dbg); end
        ticks(35);
        total++; if (state_dbg !== 3'd1) begin bad++; $display("FAIL to_state_t107 got=%0d want=1", state_dbg); end
        tick();
        total++; if (state_dbg !== 3'd4) begin bad++; $display("FAIL to_state_t108 got=%0d want=4", state_dbg); end
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL to_fault_t108 got=%b want=1", fault); end
        total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL to_pll_rst_t108 got=%b want=1", pll_rst); end
        total++; if (retry_count !== RCW'(3)) begin bad++; $display("FAIL to_retry_t108 got=%0d want=3", retry_count); end
        locked_in = 1'b1;
        ticks(12);
        total++; if (state_dbg !== 3'd4) begin bad++; $display("FAIL to_fault_hold_state got=%0d want=4", state_dbg); end
        total++; if (sys_rst !== 1'b1) begin bad++; $display("FAIL to_fault_hold_sys_rst got=%b want=1", sys_rst); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL to_rst_fault got=%b want=0", fault); end
        total++; if (retry_count !== '0) begin bad++; $display("FAIL to_rst_retry got=%0d want=0", retry_count); end
        total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL to_rst_state got=%0d want=0", state_dbg); end
    endtask

    task automatic test_retry_clear();
        do_reset(1'b0);
        ticks(36);
        total++; if (retry_count !== RCW'(1)) begin bad++; $display("FAIL rc_retry_t36 got=%0d want=1", retry_count); end
        locked_in = 1'b1;
        ticks(12);
        total++; if (state_dbg !== 3'd2) begin bad++; $display("FAIL rc_state_t48 got=%0d want=2", state_dbg); end
        total++; if (retry_count !== RCW'(1)) begin bad++; $display("FAIL rc_retry_t48 got=%0d want=1", retry_count); end
        tick();
        total++; if (state_dbg !== 3'd3) begin bad++; $display("FAIL rc_state_t49 got=%0d want=3", state_dbg); end
        total++; if (retry_count !== RCW'(0)) begin bad++; $display("FAIL rc_retry_t49 got=%0d want=0", retry_count); end
    endtask

    task automatic test_lock_loss();
        do_reset(1'b1);
        ticks(13);
        total++; if (state_dbg !== 3'd3) begin bad++; $display("FAIL ll_state_t13 got=%0d want=3", state_dbg); end
        total++; if (retry_count !== '0) begin bad++; $display("FAIL ll_retry_t13 got=%0d want=0", retry_count); end
        ticks(3);
        locked_in = 1'b0;
        ticks(2);
        total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL ll_pulse_t18 got=%b want=0", lock_lost); end
        total++; if (sys_rst !== 1'b0) begin bad++; $display("FAIL ll_sys_rst_t18 got=%b want=0", sys_rst); end
        tick();
        total++; if (lock_lost !== 1'b1) begin bad++; $display("FAIL ll_pulse_t19 got=%b want=1", lock_lost); end
        total++; if (sys_rst !== 1'b1) begin bad++; $display("FAIL ll_sys_rst_t19 got=%b want=1", sys_rst); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL ll_ready_t19 got=%b want=0", ready); end
        total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL ll_state_t19 got=%0d want=0", state_dbg); end
        tick();
        total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL ll_pulse_t20 got=%b want=0", lock_lost); end
        locked_in = 1'b1;
        ticks(11);
        total++; if (state_dbg !== 3'd2) begin bad++; $display("FAIL ll_state_t31 got=%0d want=2", state_dbg); end
        tick();
        total++; if (state_dbg !== 3'd3) begin bad++; $display("FAIL ll_state_t32 got=%0d want=3", state_dbg); end
        total++; if (sys_rst !== 1'b0) begin bad++; $display("FAIL ll_sys_rst_t32 got=%b want=0", sys_rst); end
    endtask

    task automatic test_soft_reset();
        do_reset(1'b1);
        ticks(13);
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        total++; if (sys_rst !== 1'b1) begin bad++; $display("FAIL sr_sys_rst_t14 got=%b want=1", sys_rst); end
        total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL sr_lock_lost_t14 got=%b want=0", lock_lost); end
        total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL sr_pll_rst_t14 got=%b want=1", pll_rst); end
        ticks(3);
        total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL sr_pll_rst_t17 got=%b want=1", pll_rst); end
        tick();
        total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL sr_pll_rst_t18 got=%b want=0", pll_rst); end
        total++; if (state_dbg !== 3'd1) begin bad++; $display("FAIL sr_state_t18 got=%0d want=1", state_dbg); end
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        total++; if (state_dbg !== 3'd2) begin bad++; $display("FAIL sr_ignored_state got=%0d want=2", state_dbg); end
        total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL sr_ignored_pll_rst got=%b want=0", pll_rst); end
        ticks(8);
        total++; if (state_dbg !== 3'd3) begin bad++; $display("FAIL sr_state_t27 got=%0d want=3", state_dbg); end
        // Lock loss and soft request on the same evaluation edge.
        locked_in = 1'b0;
        ticks(2);
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        total++; if (lock_lost !== 1'b1) begin bad++; $display("FAIL sr_both_lock_lost got=%b want=1", lock_lost); end
        total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL sr_both_state got=%0d want=0", state_dbg); end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1);
        ticks(7);
        total++; if (state_dbg !== 3'd2) begin bad++; $display("FAIL ar_state_pre got=%0d want=2", state_dbg); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL ar_pll_rst got=%b want=1", pll_rst); end
        total++; if (sys_rst !== 1'b1) begin bad++; $display("FAIL ar_sys_rst got=%b want=1", sys_rst); end
        total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL ar_state got=%0d want=0", state_dbg); end
        total++; if (clk !== 1'b1) begin bad++; $display("FAIL ar_before_edge clk=%b want=1", clk); end
        ticks(2);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_timeout();
        test_retry_clear();
        test_lock_loss();
        test_soft_reset();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
